sma_ds_inv: RTL and testbench
=============================

SMA_DS_INV -- requirements
Module: sma_ds_inv

Interface
REQ-001 Parameters: none; data width fixed at 16-bit signed samples and 18-bit signed window sums, window length fixed at 4.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous stream restart, active-high.
- s_valid  input  1  window sum on s is valid.
- s_ready  output  1  block accepts s this cycle.
- s  input  18  signed 4-sample window sum S[n] = x[n]+x[n-1]+x[n-2]+x[n-3].
- m_valid  output  1  recovered sample on x is valid.
- m_ready  input  1  downstream accepts x this cycle.
- x  output  16  signed recovered sample.
- err  output  1  sticky flag: a recovered sample saturated.

Function
REQ-003 The block SHALL recover the 4-tap moving-sum input stream: x[n] = S[n] - S[n-1] + x[n-4], with S[-1] and x[-1..-4] = 0 after reset or clr.
REQ-004 The block SHALL hold internal state: s_prev (18b signed) and history h1..h4 (16b signed, h1 newest).
REQ-005 Handshake: an input is accepted when s_valid && s_ready; s_ready SHALL equal (!m_valid || m_ready) && !clr.
REQ-006 On accept, the block SHALL compute r = s - s_prev + h4 in at least 20-bit signed arithmetic with sign extension of all operands.
REQ-007 Saturation: if r > 32767 the result SHALL be 32767; if r < -32768 it SHALL be -32768; in either case err SHALL be set and SHALL stay set until rst or clr.
REQ-008 On accept, the saturated result SHALL load x and the block SHALL set m_valid=1; s_prev SHALL take s; history SHALL shift h4<=h3, h3<=h2, h2<=h1, h1<=result.
REQ-009 Latency: x and m_valid SHALL appear exactly 1 cycle after the accepting edge; throughput SHALL be 1 sample/cycle while m_ready=1.
REQ-010 When m_valid && m_ready and there is no accept in the same cycle, m_valid SHALL clear next edge.
REQ-011 When a transfer out and an accept coincide, m_valid SHALL stay 1 and x SHALL take the new result.
REQ-012 While m_valid && !m_ready: x, m_valid, s_prev and history SHALL hold, and s_ready SHALL be 0.
REQ-013 Inputs on s SHALL be ignored when s_valid=0 or s_ready=0; no state change.
REQ-014 clr SHALL have priority over any accept in the same cycle: next edge s_prev, h1..h4, x, err := 0 and m_valid := 0; the pending sample is not accepted.

Reset
REQ-015 While rst=0 (asynchronous assert), the block SHALL force: x=0, m_valid=0, err=0, s_prev=0, h1..h4=0; s_ready SHALL be 1 whenever clr=0.
REQ-016 Deassertion of rst SHALL be consumed synchronously; the first accept is allowed on the first posedge with rst=1.
REQ-017 Reset asserted mid-operation SHALL discard any unconsumed output without completing the handshake.

Verification
REQ-018 Basic: reset, m_ready=1, feed s = 100, 300, 600, 1000, 1400 back-to-back -> x = 100, 200, 300, 400, 500 on consecutive cycles, each 1 cycle after accept, err=0.
REQ-019 Backpressure:
- Setup: s = 100, then hold m_ready=0 and present s=300.
- Required while m_ready=0: s_ready=0, x stays 100, m_valid=1.
- Required after m_ready=1: 300 is accepted and x=200 on the next cycle.
REQ-020 Saturation: after reset, s=131071 -> x=32767, err=1; then s=131071 again -> x=0 (131071-131071+0), err stays 1.
REQ-021 Negative range: after reset, s = -32768, -65536 -> x = -32768, -32768, err=0.
REQ-022 clr mid-stream:
- Setup: after three samples with err=1, assert clr for 1 cycle with s_valid=1.
- Required: s_ready=0 during clr, and the sample is not consumed.
- Required next cycle: m_valid=0, err=0.
- Required after: s=50 -> x=50.
REQ-023 Async reset: assert rst=0 between clock edges while m_valid=1 -> m_valid, x, err go to 0 before the next posedge; after release, s=7 -> x=7.

Source files
------------

// File: rtl/sma_ds_inv_if.sv
// Streaming bus for the moving-sum inverter: window sums in, recovered samples out.
// The master side drives window sums and downstream ready; the slave side is the inverter.
interface sma_ds_inv_if;
  logic               s_valid;
  logic               s_ready;
  logic signed [17:0] s;
  logic               m_valid;
  logic               m_ready;
  logic signed [15:0] x;
  logic               err;

  modport master (
    output s_valid, s, m_ready,
    input  s_ready, m_valid, x, err
  );

  modport slave (
    input  s_valid, s, m_ready,
    output s_ready, m_valid, x, err
  );
endinterface

// File: rtl/sma_ds_inv.sv
// Inverts a 4-tap moving sum: x[n] = S[n] - S[n-1] + x[n-4], saturated to 16 bits
// with a sticky overflow flag and a one-deep registered output stage.
module sma_ds_inv (
  input logic         clk,
  input logic         rst,
  input logic         clr,
  sma_ds_inv_if.slave bus
);
  localparam int unsigned SW = 18;
  localparam int unsigned XW = 16;
  localparam int unsigned RW = 20;
  localparam logic signed [RW-1:0] X_MAX = 20'sd32767;
  localparam logic signed [RW-1:0] X_MIN = -20'sd32768;

  logic signed [SW-1:0] s_prev;
  logic signed [XW-1:0] h1, h2, h3, h4;
  logic signed [XW-1:0] x_q;
  logic                 m_valid_q;
  logic                 err_q;

  logic                 accept;
  logic                 sat;
  logic signed [RW-1:0] r;
  logic signed [XW-1:0] res;

  // Output stage can take a new result when empty or draining; clr blocks intake.
  assign bus.s_ready = (!m_valid_q || bus.m_ready) && !clr;
  assign accept      = bus.s_valid && bus.s_ready;

  assign bus.x       = x_q;
  assign bus.m_valid = m_valid_q;
  assign bus.err     = err_q;

  // Difference plus the sample that just left the window, clamped to 16 bits.
  always_comb begin
    r   = RW'(bus.s) - RW'(s_prev) + RW'(h4);
    sat = 1'b0;
    res = r[XW-1:0];
    if (r > X_MAX) begin
      res = 16'sh7FFF;
      sat = 1'b1;
    end else if (r < X_MIN) begin
      res = 16'sh8000;
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_prev    <= '0;
      h1        <= '0;
      h2        <= '0;
      h3        <= '0;
      h4        <= '0;
      x_q       <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (clr) begin
      s_prev    <= '0;
      h1        <= '0;
      h2        <= '0;
      h3        <= '0;
      h4        <= '0;
      x_q       <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept) begin
      s_prev    <= bus.s;
      h4        <= h3;
      h3        <= h2;
      h2        <= h1;
      h1        <= res;
      x_q       <= res;
      m_valid_q <= 1'b1;
      err_q     <= err_q | sat;
    end else if (m_valid_q && bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sma_ds_inv.sv
// Self-checking bench for sma_ds_inv: directed scenarios plus a randomized stream
// built forward from random samples and checked against those samples.
module tb_sma_ds_inv;
  logic clk;
  logic rst;
  logic clr;
  int   n_pass  = 0;
  int   n_total = 0;

  sma_ds_inv_if bus ();

  sma_ds_inv dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_total++; if (bus.m_valid !== 1'b0) $display("FAIL rst_m_valid: got %0b want 0", bus.m_valid); else n_pass++;
    n_total++; if (bus.x !== 16'sd0) $display("FAIL rst_x: got %0d want 0", bus.x); else n_pass++;
    n_total++; if (bus.err !== 1'b0) $display("FAIL rst_err: got %0b want 0", bus.err); else n_pass++;
    n_total++; if (bus.s_ready !== 1'b1) $display("FAIL rst_s_ready: got %0b want 1", bus.s_ready); else n_pass++;
    clr = 1'b1;
    #1;
    n_total++; if (bus.s_ready !== 1'b0) $display("FAIL rst_clr_s_ready: got %0b want 0", bus.s_ready); else n_pass++;
    clr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int sv[5] = '{100, 300, 600, 1000, 1400};
    int xv[5] = '{100, 200, 300, 400, 500};
    apply_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = 1'b1;
      bus.s = 18'(sv[i]);
      @(negedge clk);
      n_total++; if (bus.m_valid !== 1'b1) $display("FAIL basic_m_valid[%0d]: got %0b want 1", i, bus.m_valid); else n_pass++;
      n_total++; if (bus.x !== 16'(xv[i])) $display("FAIL basic_x[%0d]: got %0d want %0d", i, bus.x, xv[i]); else n_pass++;
    end
    bus.s_valid = 1'b0;
    n_total++; if (bus.err !== 1'b0) $display("FAIL basic_err: got %0b want 0", bus.err); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.m_valid !== 1'b0) $display("FAIL basic_drain: got %0b want 0", bus.m_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s = 18'sd100;
    @(negedge clk);
    n_total++; if (bus.x !== 16'sd100) $display("FAIL bp_first_x: got %0d want 100", bus.x); else n_pass++;
    bus.m_ready = 1'b0;
    bus.s = 18'sd300;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (bus.s_ready !== 1'b0) $display("FAIL bp_s_ready[%0d]: got %0b want 0", i, bus.s_ready); else n_pass++;
      @(negedge clk);
      n_total++; if (bus.x !== 16'sd100) $display("FAIL bp_hold_x[%0d]: got %0d want 100", i, bus.x); else n_pass++;
      n_total++; if (bus.m_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %0b want 1", i, bus.m_valid); else n_pass++;
    end
    bus.m_ready = 1'b1;
    #1;
    n_total++; if (bus.s_ready !== 1'b1) $display("FAIL bp_release_ready: got %0b want 1", bus.s_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.x !== 16'sd200) $display("FAIL bp_release_x: got %0d want 200", bus.x); else n_pass++;
    n_total++; if (bus.m_valid !== 1'b1) $display("FAIL bp_release_valid: got %0b want 1", bus.m_valid); else n_pass++;
    bus.s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    apply_reset();
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s = 18'sd131071;
    @(negedge clk);
    n_total++; if (bus.x !== 16'sd32767) $display("FAIL sat_x0: got %0d want 32767", bus.x); else n_pass++;
    n_total++; if (bus.err !== 1'b1) $display("FAIL sat_err0: got %0b want 1", bus.err); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.x !== 16'sd0) $display("FAIL sat_x1: got %0d want 0", bus.x); else n_pass++;
    n_total++; if (bus.err !== 1'b1) $display("FAIL sat_err1: got %0b want 1", bus.err); else n_pass++;
    bus.s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_negative();
    apply_reset();
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s = -18'sd32768;
    @(negedge clk);
    n_total++; if (bus.x !== -16'sd32768) $display("FAIL neg_x0: got %0d want -32768", bus.x); else n_pass++;
    bus.s = -18'sd65536;
    @(negedge clk);
    n_total++; if (bus.x !== -16'sd32768) $display("FAIL neg_x1: got %0d want -32768", bus.x); else n_pass++;
    n_total++; if (bus.err !== 1'b0) $display("FAIL neg_err: got %0b want 0", bus.err); else n_pass++;
    bus.s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clr();
    apply_reset();
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s = 18'sd131071;
    @(negedge clk);
    @(negedge clk);
    bus.s = 18'sd0;
    @(negedge clk);
    n_total++; if (bus.x !== -16'sd32768) $display("FAIL clr_setup_x: got %0d want -32768", bus.x); else n_pass++;
    n_total++; if (bus.err !== 1'b1) $display("FAIL clr_setup_err: got %0b want 1", bus.err); else n_pass++;
    clr = 1'b1;
    bus.s = 18'sd999;
    #1;
    n_total++; if (bus.s_ready !== 1'b0) $display("FAIL clr_s_ready: got %0b want 0", bus.s_ready); else n_pass++;
    @(negedge clk);
    clr = 1'b0;
    n_total++; if (bus.m_valid !== 1'b0) $display("FAIL clr_m_valid: got %0b want 0", bus.m_valid); else n_pass++;
    n_total++; if (bus.err !== 1'b0) $display("FAIL clr_err: got %0b want 0", bus.err); else n_pass++;
    bus.s = 18'sd50;
    @(negedge clk);
    n_total++; if (bus.x !== 16'sd50) $display("FAIL clr_after_x: got %0d want 50", bus.x); else n_pass++;
    bus.s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s = 18'sd131071;
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    n_total++; if (bus.m_valid !== 1'b1 || bus.err !== 1'b1) $display("FAIL async_setup: got valid=%0b err=%0b want 1/1", bus.m_valid, bus.err); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++; if (bus.m_valid !== 1'b0) $display("FAIL async_m_valid: got %0b want 0", bus.m_valid); else n_pass++;
    n_total++; if (bus.x !== 16'sd0) $display("FAIL async_x: got %0d want 0", bus.x); else n_pass++;
    n_total++; if (bus.err !== 1'b0) $display("FAIL async_err: got %0b want 0", bus.err); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s = 18'sd7;
    @(negedge clk);
    n_total++; if (bus.x !== 16'sd7 || bus.m_valid !== 1'b1) $display("FAIL async_after: got x=%0d valid=%0b want 7/1", bus.x, bus.m_valid); else n_pass++;
    bus.s_valid = 1'b0;
    @(negedge clk);
  endtask

  // Random 16-bit samples are summed forward into window sums; the recovered stream
  // must reproduce the samples in order under random valid/ready patterns.
  task automatic test_random_stream();
    localparam int N = 300;
    int  xs[N];
    int  sums[N];
    int  sent = 0;
    int  recv = 0;
    bit  mv   = 1'b0;
    bit  sv, mr, rdy;
    logic signed [15:0] xe = '0;
    for (int n = 0; n < N; n++) begin
      xs[n] = int'($urandom_range(0, 65535)) - 32768;
      sums[n] = 0;
      for (int k = 0; k < 4; k++)
        if (n - k >= 0) sums[n] += xs[n - k];
    end
    apply_reset();
    for (int cyc = 0; cyc < 4000 && (sent < N || mv); cyc++) begin
      n_total++; if (bus.m_valid !== mv) $display("FAIL rnd_m_valid@%0d: got %0b want %0b", cyc, bus.m_valid, mv); else n_pass++;
      if (mv) begin
        n_total++; if (bus.x !== xe) $display("FAIL rnd_x@%0d: got %0d want %0d", cyc, bus.x, xe); else n_pass++;
      end
      sv = (sent < N) && ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 3) != 0);
      bus.s_valid = sv;
      bus.m_ready = mr;
      bus.s = (sent < N) ? 18'(sums[sent]) : 18'sd0;
      rdy = !mv || mr;
      #1;
      n_total++; if (bus.s_ready !== rdy) $display("FAIL rnd_s_ready@%0d: got %0b want %0b", cyc, bus.s_ready, rdy); else n_pass++;
      if (mv && mr) recv++;
      if (sv && rdy) begin
        mv = 1'b1;
        xe = 16'(xs[sent]);
        sent++;
      end else if (mv && mr) begin
        mv = 1'b0;
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    n_total++; if (sent != N || mv) $display("FAIL rnd_timeout: got sent=%0d pending=%0b want %0d/0", sent, mv, N); else n_pass++;
    n_total++; if (recv != N) $display("FAIL rnd_recv_count: got %0d want %0d", recv, N); else n_pass++;
    n_total++; if (bus.err !== 1'b0) $display("FAIL rnd_err: got %0b want 0", bus.err); else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    clr = 1'b0;
    bus.s_valid = 1'b0;
    bus.s = '0;
    bus.m_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_negative();
    test_clr();
    test_async_reset();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
